// File: rtl/hilo_div_unit.sv
// hilo_div_unit: HI/LO register pair with an iterative radix-2 divider (DATA_W cycles).
// Define HILO_BYPASS_EN to forward the value being written to hi/lo in the same cycle.
module hilo_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              es_valid,
    input  logic              flush,
    input  logic              op_mult,
    input  logic              op_multu,
    input  logic              op_div,
    input  logic              op_divu,
    input  logic              op_mthi,
    input  logic              op_mtlo,
    input  logic [DATA_W-1:0] mult_hi,
    input  logic [DATA_W-1:0] mult_lo,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] dvd, dsr, rem, hi_r, lo_r, hi_nx, lo_nx, a_mag, b_mag;
    logic [DATA_W:0] rem_sh;
    logic qs, rs, dz, start, ge, hi_we, lo_we, idle_ok;

    assign start   = es_valid & (op_div | op_divu) & (state == IDLE) & ~flush;
    assign idle_ok = es_valid & (state == IDLE) & ~flush & ~(op_div | op_divu);
    assign busy    = start | (state == RUN);
    assign done    = (state == FIN) & ~flush;
    assign a_mag   = (op_div & src1[DATA_W-1]) ? -src1 : src1;
    assign b_mag   = (op_div & src2[DATA_W-1]) ? -src2 : src2;
    // one extra remainder bit keeps the trial compare free of overflow
    assign rem_sh  = {rem, dvd[DATA_W-1]};
    assign ge      = rem_sh >= {1'b0, dsr};

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = IDLE;
        else if (state == IDLE)
            state_nx = start ? RUN : IDLE;
        else if (state == RUN)
            state_nx = (cnt == CW'(DATA_W - 1)) ? FIN : RUN;
        else
            state_nx = IDLE;
    end

    // on divide-by-zero the loop leaves |src1| in rem, so the rs fix restores raw src1
    always_comb begin
        hi_we = 1'b0;
        lo_we = 1'b0;
        hi_nx = hi_r;
        lo_nx = lo_r;
        if (done) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            hi_nx = rs ? -rem : rem;
            lo_nx = dz ? '1 : (qs ? -dvd : dvd);
        end else if (idle_ok & (op_mult | op_multu)) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            hi_nx = mult_hi;
            lo_nx = mult_lo;
        end else if (idle_ok) begin
            hi_we = op_mthi;
            lo_we = op_mtlo;
            hi_nx = src1;
            lo_nx = src1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
            dvd   <= '0;
            dsr   <= '0;
            rem   <= '0;
            qs    <= 1'b0;
            rs    <= 1'b0;
            dz    <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                dvd <= a_mag;
                dsr <= b_mag;
                rem <= '0;
                cnt <= '0;
                qs  <= op_div & (src1[DATA_W-1] ^ src2[DATA_W-1]);
                rs  <= op_div & src1[DATA_W-1];
                dz  <= (src2 == '0);
            end else if (state == RUN) begin
                rem <= ge ? DATA_W'(rem_sh - {1'b0, dsr}) : rem_sh[DATA_W-1:0];
                dvd <= {dvd[DATA_W-2:0], ge};
                cnt <= cnt + 1'b1;
            end
            if (hi_we)
                hi_r <= hi_nx;
            if (lo_we)
                lo_r <= lo_nx;
        end
    end

`ifdef HILO_BYPASS_EN
    assign hi = hi_we ? hi_nx : hi_r;
    assign lo = lo_we ? lo_nx : lo_r;
`else
    assign hi = hi_r;
    assign lo = lo_r;
`endif
endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: vector table, hand sequences and randomized ops against a reference model.
module tb_hilo_div_unit;
    logic clk = 0, reset = 1, es_valid, flush, op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic [31:0] mult_hi, mult_lo, src1, src2, hi, lo;
    logic busy, done;
    int errors = 0, checks = 0;

    hilo_div_unit #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .es_valid(es_valid), .flush(flush),
        .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
        .op_mthi(op_mthi), .op_mtlo(op_mtlo), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .src1(src1), .src2(src2), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } dv_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        es_valid = 0; flush = 0; op_mult = 0; op_multu = 0;
        op_div = 0; op_divu = 0; op_mthi = 0; op_mtlo = 0;
    endtask

    function automatic void model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        if (b == 0) begin
            l = 32'hFFFF_FFFF; h = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = a; h = 0;
        end else if (sg) begin
            l = $signed(a) / $signed(b); h = $signed(a) % $signed(b);
        end else begin
            l = a / b; h = a % b;
        end
    endfunction

    task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] h, output logic [31:0] l);
        int k, bc;
        es_valid = 1; op_div = sg; op_divu = !sg; src1 = a; src2 = b;
        #1;
        chk("busy_start", {31'b0, busy}, 1);
        tick();
        clr();
        k = 1; bc = 1;
        while (k <= 40 && !done) begin
            bc += busy;
            tick();
            k++;
        end
        chk("done_latency", k, 33);
        chk("busy_cycles", bc, 33);
        tick();
        chk("done_pulse", {31'b0, done}, 0);
        h = hi; l = lo;
    endtask

    initial begin
        dv_t tbl[8];
        logic [31:0] h, l, eh, el, ph, pl;
        bit seen;
        tbl[0] = '{1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[1] = '{0, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF};
        tbl[2] = '{1, 32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF};
        tbl[3] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        tbl[4] = '{1, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
        tbl[5] = '{0, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFF};
        tbl[6] = '{1, 32'hFFFF_FFF8, 32'h0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
        tbl[7] = '{0, 32'h64,        32'h7,         32'h2,         32'hE};
        clr();
        mult_hi = 0; mult_lo = 0; src1 = 0; src2 = 0;
        repeat (2) tick();
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        reset = 0;

        es_valid = 1; op_multu = 1; mult_hi = 32'h1; mult_lo = 32'hFFFF_FFFE;
        tick(); clr();
        chk("multu_hi", hi, 32'h1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        es_valid = 1; op_mult = 1; op_mthi = 1; mult_hi = 32'hFFFF_FFFF; mult_lo = 32'h8; src1 = 32'h99;
        tick(); clr();
        chk("mult_prio_hi", hi, 32'hFFFF_FFFF);
        chk("mult_prio_lo", lo, 32'h8);

        for (int i = 0; i < 8; i++) begin
            es_valid = 1; op_mthi = 1; op_mtlo = 1; src1 = 32'hA5A5_A5A5;
            tick(); clr();
            chk("preload_hi", hi, 32'hA5A5_A5A5);
            chk("preload_lo", lo, 32'hA5A5_A5A5);
            run_div(tbl[i].sg, tbl[i].a, tbl[i].b, h, l);
            chk($sformatf("tbl%0d_hi", i), h, tbl[i].eh);
            chk($sformatf("tbl%0d_lo", i), l, tbl[i].el);
        end

        op_mult = 1; op_mthi = 1; mult_hi = 32'h1111_1111; mult_lo = 32'h2222_2222;
        run_div(1, 32'd20, 32'd6, h, l);
        chk("div_prio_hi", h, 32'd2);
        chk("div_prio_lo", l, 32'd3);

        ph = hi; pl = lo;
        es_valid = 1; op_div = 1; src1 = 32'd100; src2 = 32'd3;
        tick(); clr();
        repeat (4) tick();
        es_valid = 1; op_mthi = 1; src1 = 32'h77;
        tick(); clr();
        chk("mt_in_run", hi, ph);
        repeat (4) tick();
        flush = 1; es_valid = 1; op_mult = 1; mult_hi = 32'hDEAD_BEEF;
        tick(); clr();
        chk("flush_busy", {31'b0, busy}, 0);
        seen = 0;
        repeat (40) begin
            seen |= done;
            tick();
        end
        chk("flush_no_done", {31'b0, seen}, 0);
        chk("flush_hi", hi, ph);
        chk("flush_lo", lo, pl);
        es_valid = 1; op_mult = 1; flush = 1; op_div = 1;
        #1;
        chk("flush_start_busy", {31'b0, busy}, 0);
        tick(); clr();
        chk("flush_mult_hi", hi, ph);
        chk("flush_mult_lo", lo, pl);
`ifdef HILO_BYPASS_EN
        es_valid = 1; op_mthi = 1; src1 = 32'h55;
        #1;
        chk("bypass_hi", hi, 32'h55);
        tick(); clr();
`endif

        es_valid = 1; op_divu = 1; src1 = 32'd50; src2 = 32'd7;
        tick(); clr();
        repeat (5) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_mid_busy", {31'b0, busy}, 0);
        chk("rst_mid_hi", hi, 0);
        chk("rst_mid_lo", lo, 0);
        seen = 0;
        repeat (40) begin
            seen |= done;
            tick();
        end
        chk("rst_mid_no_done", {31'b0, seen}, 0);

        eh = 0; el = 0;
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 3);
            if (r == 0) begin
                es_valid = 1; op_mult = $urandom_range(0, 1); op_multu = !op_mult;
                mult_hi = $urandom; mult_lo = $urandom;
                eh = mult_hi; el = mult_lo;
                tick(); clr();
            end else if (r == 1) begin
                es_valid = 1; op_mthi = $urandom_range(0, 1); op_mtlo = $urandom_range(0, 1); src1 = $urandom;
                if (op_mthi) eh = src1;
                if (op_mtlo) el = src1;
                tick(); clr();
            end else begin
                bit sg;
                logic [31:0] a, b;
                sg = $urandom_range(0, 1);
                a = $urandom;
                b = ($urandom_range(0, 7) == 0) ? 32'h0 :
                    ($urandom_range(0, 1) ? 32'($urandom) : 32'($urandom_range(1, 300)));
                if ($urandom_range(0, 1)) b = -b;
                model(sg, a, b, eh, el);
                run_div(sg, a, b, h, l);
            end
            chk($sformatf("rnd%0d_hi", i), hi, eh);
            chk($sformatf("rnd%0d_lo", i), lo, el);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
